// File: rtl/secuenciador_jericalla.sv
// Instruction sequencer and RAW hazard controller for the two-buffer Jericalla datapath.
// Issues ROM words in order, inserts NOP bubbles on dependences, then drains three NOPs.
module secuenciador_jericalla #(
   parameter int          PC_W      = 8,
   parameter logic [7:0]  WB_MASK   = 8'b0111_1111,
   parameter logic [17:0] NOP_INSTR = 18'b111_00000_00000_00000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [PC_W-1:0] end_addr,
   output logic [PC_W-1:0] imem_addr,
   input  logic [17:0]     imem_data,
   output logic [17:0]     instr_out,
   output logic            busy,
   output logic            done,
   output logic [15:0]     stall_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] end_q;
   logic [17:0]     instr_p1;
   logic            vld_p0;
   logic            vld_p1;
   logic [1:0]      drain_cnt;
   logic            hazard;
   logic            wr_p0;
   logic            wr_p1;
   logic            accept;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign imem_addr = pc;
   assign accept    = ((state == IDLE) || (state == DONE)) && start;

   // A slot only blocks the candidate if it holds a real instruction whose opcode writes.
   always_comb begin
      wr_p0  = vld_p0 && WB_MASK[instr_out[17:15]];
      wr_p1  = vld_p1 && WB_MASK[instr_p1[17:15]];
      hazard = (wr_p0 && ((imem_data[9:5] == instr_out[14:10]) ||
                          (imem_data[4:0] == instr_out[14:10]))) ||
               (wr_p1 && ((imem_data[9:5] == instr_p1[14:10]) ||
                          (imem_data[4:0] == instr_p1[14:10])));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = RUN;
         RUN:        if (!hazard && (pc == end_q)) state_nxt = DRAIN;
         DRAIN:      if (drain_cnt == 2'd2) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
   end

   // Issue stage: instr_out is decode (p0), instr_p1 is execute.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= '0;
         end_q     <= '0;
         instr_out <= NOP_INSTR;
         instr_p1  <= NOP_INSTR;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         drain_cnt <= 2'd0;
         stall_cnt <= 16'd0;
      end else begin
         instr_p1 <= instr_out;
         vld_p1   <= vld_p0;
         case (state)
            RUN: begin
               if (hazard) begin
                  instr_out <= NOP_INSTR;
                  vld_p0    <= 1'b0;
                  stall_cnt <= sat_inc(stall_cnt);
               end else begin
                  instr_out <= imem_data;
                  vld_p0    <= 1'b1;
                  if (pc == end_q) drain_cnt <= 2'd0;
                  else             pc        <= pc + 1'b1;
               end
            end
            DRAIN: begin
               instr_out <= NOP_INSTR;
               vld_p0    <= 1'b0;
               drain_cnt <= drain_cnt + 2'd1;
            end
            default: begin
               instr_out <= NOP_INSTR;
               vld_p0    <= 1'b0;
               if (accept) begin
                  pc        <= '0;
                  end_q     <= end_addr;
                  stall_cnt <= 16'd0;
                  vld_p1    <= 1'b0;
                  drain_cnt <= 2'd0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_jericalla.sv
// Directed bench for secuenciador_jericalla: hand-computed issue sequences per program.
module tb_secuenciador_jericalla;

   localparam logic [17:0] NOP = 18'b111_00000_00000_00000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  end_addr;
   logic [7:0]  imem_addr;
   logic [17:0] imem_data;
   logic [17:0] instr_out;
   logic        busy;
   logic        done;
   logic [15:0] stall_cnt;

   logic [17:0] rom [256];
   logic [17:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   assign imem_data = rom[imem_addr];

   always #5 clk = ~clk;

   secuenciador_jericalla dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .end_addr  (end_addr),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .instr_out (instr_out),
      .busy      (busy),
      .done      (done),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom;
      for (int i = 0; i < 256; i++) rom[i] = NOP;
   endtask

   // Accept edge E0, then compare instr_out at E1..E(n) against exp_q; start stays high for 'hold' edges.
   task automatic run_prog(input string name, input logic [7:0] last, input int hold,
                           input logic [15:0] exp_stall);
      end_addr = last;
      start    = 1'b1;
      tick();
      check({name, "_e0_busy"}, busy, 1);
      check({name, "_e0_addr"}, imem_addr, 0);
      check({name, "_e0_stall"}, stall_cnt, 0);
      for (int e = 1; e <= exp_q.size(); e++) begin
         start = (e <= hold);
         tick();
         check($sformatf("%s_e%0d_instr", name, e), instr_out, exp_q[e-1]);
         if (e < exp_q.size()) begin
            check($sformatf("%s_e%0d_busy", name, e), busy, 1);
            check($sformatf("%s_e%0d_done", name, e), done, 0);
         end else begin
            check($sformatf("%s_e%0d_busy", name, e), busy, 0);
            check($sformatf("%s_e%0d_done", name, e), done, 1);
         end
      end
      start = 1'b0;
      check({name, "_stall"}, stall_cnt, exp_stall);
      check({name, "_pc_end"}, imem_addr, last);
      tick();
      check({name, "_hold_done"}, done, 1);
      check({name, "_hold_nop"}, instr_out, NOP);
   endtask

   initial begin
      clear_rom();
      rst      = 1'b1;
      start    = 1'b0;
      end_addr = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_instr", instr_out, NOP);
      check("rst_addr", imem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall_cnt, 0);

      // Independent program: four back-to-back issues then three drain NOPs.
      rom[0] = 18'b000_00011_00001_00010;
      rom[1] = 18'b000_00100_00101_00110;
      rom[2] = 18'b001_00111_01000_01001;
      rom[3] = 18'b010_01010_01011_01100;
      exp_q = '{rom[0], rom[1], rom[2], rom[3], NOP, NOP, NOP};
      run_prog("indep", 8'd3, 0, 16'd0);

      // Distance-1 RAW on RA1: two bubbles.
      clear_rom();
      rom[0] = 18'b000_00011_00001_00010;
      rom[1] = 18'b000_00100_00011_00110;
      exp_q = '{rom[0], NOP, NOP, rom[1], NOP, NOP, NOP};
      run_prog("dist1", 8'd1, 0, 16'd2);

      // Distance-2 RAW on RA2: one bubble.
      clear_rom();
      rom[0] = 18'b000_00011_00001_00010;
      rom[1] = 18'b000_00100_00101_00110;
      rom[2] = 18'b000_00111_01000_00011;
      exp_q = '{rom[0], rom[1], NOP, rom[2], NOP, NOP, NOP};
      run_prog("dist2", 8'd2, 0, 16'd1);

      // Same program, producer opcode 7 does not write; also a restart from DONE.
      rom[0] = 18'b111_00011_00001_00010;
      exp_q = '{rom[0], rom[1], rom[2], NOP, NOP, NOP};
      run_prog("nowb", 8'd2, 0, 16'd0);

      // Reset during a stall, with start raised alongside: reset wins.
      clear_rom();
      rom[0] = 18'b000_00011_00001_00010;
      rom[1] = 18'b000_00100_00011_00110;
      end_addr = 8'd1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("mid_stalling", stall_cnt, 1);
      check("mid_pc_held", imem_addr, 1);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_addr", imem_addr, 0);
      check("mid_rst_stall", stall_cnt, 0);
      check("mid_rst_instr", instr_out, NOP);
      tick();
      check("mid_rst_idle", busy, 0);

      // start held high through E1..E2 of a run must not disturb the sequence.
      clear_rom();
      rom[0] = 18'b000_00011_00001_00010;
      rom[1] = 18'b000_00100_00101_00110;
      rom[2] = 18'b001_00111_01000_01001;
      rom[3] = 18'b010_01010_01011_01100;
      exp_q = '{rom[0], rom[1], rom[2], rom[3], NOP, NOP, NOP};
      run_prog("runstart", 8'd3, 2, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/secuenciador_jericalla.md
# secuenciador_jericalla

Instruction sequencer and hazard controller for the two-buffer Jericalla datapath.
- Fetches 18-bit instructions from a combinational instruction ROM and presents them, registered, on the datapath instruction input.
- Detects read-after-write dependences against the two instructions still in flight and inserts NOP bubbles until the dependence clears.
- Drains the pipeline after the last instruction and reports completion.

## Interface

Parameters:
- PC_W, default 8: instruction address width.
- WB_MASK, default 8'b0111_1111: bit i set means opcode i writes the register bank.
- NOP_INSTR, default 18'b111_00000_00000_00000: bubble instruction. Its opcode bit in WB_MASK is clear, and it performs no RAM write or read.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begin execution at address 0; sampled only in IDLE and DONE.
- end_addr  in  PC_W  address of the last instruction (inclusive); sampled when start is accepted.
- imem_addr  out  PC_W  ROM address; equals the PC register.
- imem_data  in  18  ROM word at imem_addr, valid in the same cycle.
- instr_out  out  18  registered instruction to the datapath (opcode [17:15], WA [14:10], RA1 [9:5], RA2 [4:0]).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- stall_cnt  out  16  bubbles inserted since the last accepted start; saturates at 16'hFFFF.

## Operation

States: IDLE, RUN, DRAIN, DONE.

**Reset** (any state, including mid-run):
- State goes to IDLE; PC=0; instr_out=NOP_INSTR; busy=0; done=0; stall_cnt=0.
- Both history slots become invalid.

**IDLE / DONE**
- instr_out is held at NOP_INSTR.
- When start=1: go to RUN; PC=0; latch end_addr; stall_cnt=0; clear history; done=0.

**RUN**
- Each cycle, the candidate C=imem_data is checked against two history slots:
  - H0 = instr_out (the instruction in decode).
  - H1 = the previous instr_out (the instruction in execute).
- Slot Hx "writes" when WB_MASK[Hx opcode]=1.
- Hazard when, for either slot that writes, C.RA1==Hx.WA or C.RA2==Hx.WA. Register 0 is not special-cased.
- On hazard:
  - instr_out<=NOP_INSTR.
  - PC holds.
  - stall_cnt increments (saturating).
- On no hazard:
  - instr_out<=C.
  - If PC==latched end_addr: go to DRAIN, drain counter=0.
  - Otherwise PC<=PC+1; PC wraps modulo 2^PC_W, and that wrap is never reached when end_addr ≥ PC.
- H1<=H0 every cycle, in every state.

**DRAIN**
- instr_out<=NOP_INSTR for 3 cycles.
- After the 3rd NOP load, go to DONE.
- PC holds at end_addr.

start is ignored in RUN and DRAIN.

## Timing

- Accept edge E0 (start=1 in IDLE): busy=1 from E0 onward, imem_addr=0.
- With no hazards, instruction k appears on instr_out at edge E(k+1).
- A consumer enters decode no earlier than 3 cycles after its producer entered decode:
  - distance-1 dependence costs 2 bubbles;
  - distance-2 dependence costs 1 bubble.
- With N instructions and S bubbles, the last instruction is issued at E(N+S), the drain NOPs at E(N+S+1..N+S+3), and busy falls / done rises at E(N+S+3).
- stall_cnt updates on the same edge the bubble loads.
- start asserted together with rst: reset wins.

## Test plan

- **Reset:** rst=1 for 2 cycles from random state → instr_out=NOP_INSTR, imem_addr=0, busy=0, done=0, stall_cnt=0.
- **Independent program:** end_addr=3; ROM {0:000_00011_00001_00010, 1:000_00100_00101_00110, 2:001_00111_01000_01001, 3:010_01010_01011_01100}; start at E0 → instr_out=I0..I3 at E1..E4, NOPs at E5–E7, done=1 after E7, stall_cnt=0.
- **Distance-1 RAW:** I0 writes R3, I1 reads RA1=3, end_addr=1 → I0 at E1, NOP at E2 and E3, I1 at E4, stall_cnt=2, done after E7.
- **Distance-2 RAW, non-writing producer:**
  - I0 writes R3, I1 independent, I2 reads RA2=3 → exactly one NOP before I2, stall_cnt=1.
  - Same program with I0 opcode 7 (WB_MASK bit 7 clear) → stall_cnt=0.
- **Reset mid-run and restart:** rst pulsed during a stall → IDLE, PC=0, stall_cnt=0. start in DONE → restart from address 0, stall_cnt cleared. start pulsed in RUN → no effect on PC or instr_out.
